rect_copy_scheduler: RTL and testbench
======================================

Name: rect_copy_scheduler

Overview:
Per-frame sequencer for the rectangle DMA copy into the GPU. On each frame event it halts the CPU and takes the data-memory read port for the DMA. It then fires a single copy_start and tracks the 64 × 6-word packet stream with word/rect indices and a valid strobe for the GPU. When the stream ends it releases the port and the CPU. Sits between the VGA timing source, the CPU stall logic, the data-memory read-port mux and the rect copy DMA.

Parameters:
RECT_COUNT, 64, rectangles per frame (DMA rect count)
WORDS_PER_RECT, 6, words per packet (0, x, y, w, h, color)
HALT_TIMEOUT, 255, cycles allowed in HALT_WAIT (used only with COPY_WATCHDOG_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
frame_start  in  1  single-cycle pulse at vblank start
cpu_halted  in  1  CPU is stalled at an instruction boundary
cpu_halt_req  out  1  request CPU stall
copy_start  out  1  single-cycle start pulse to DMA
mem_sel  out  1  1 = DMA owns data-mem read port, 0 = CPU
gpu_valid  out  1  current DMA output word is valid for GPU
gpu_word_idx  out  3  word index within packet, 0..5
gpu_rect_idx  out  6  rect index, 0..63
copy_busy  out  1  high in any state except IDLE
frame_done  out  1  single-cycle pulse when copy is complete
overrun  out  1  sticky: frame_start arrived while not IDLE
overrun_clr  in  1  clears overrun
halt_timeout  out  1  sticky watchdog flag (tied 0 without macro)

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; counters 0.
- States: IDLE, HALT_WAIT, START, COPY, RELEASE. All outputs registered or decoded from state and counters; no combinational path from inputs to outputs.
- IDLE:
  - frame_start → HALT_WAIT.
  - Outputs all 0.
- HALT_WAIT:
  - cpu_halt_req=1.
  - cpu_halted=1 → START.
  - Otherwise hold.
- START (exactly 1 cycle):
  - cpu_halt_req=1, mem_sel=1, copy_start=1.
  - Clear word and rect counters.
  - → COPY.
- COPY:
  - cpu_halt_req=1, mem_sel=1, gpu_valid=1.
  - gpu_word_idx and gpu_rect_idx driven from the counters.
  - First COPY cycle is the cycle after copy_start, which is when the DMA emits word 0.
  - Word counter increments each cycle and wraps 5→0; on wrap, rect counter increments.
  - At rect 63, word 5 → RELEASE.
  - COPY lasts exactly RECT_COUNT*WORDS_PER_RECT = 384 cycles.
- RELEASE (1 cycle):
  - mem_sel=0, cpu_halt_req=0, frame_done=1.
  - → IDLE.
- Latency from frame_start to first gpu_valid: 3 cycles if cpu_halted is already 1.
- frame_start in any state other than IDLE: set overrun and ignore the pulse. Events are not queued.
- overrun_clr and a new overrun in the same cycle: set wins.
- cpu_halted deasserting during START or COPY: ignored. The CPU must stay stalled while cpu_halt_req=1.
- Reset mid-COPY: outputs drop to 0 immediately. The DMA's own reset must be asserted together with this one, so system reset is shared.
- Counter widths: word 3 bits, rect 6 bits; rect counter wraps to 0 naturally after 63.

Optional Feature:
COPY_WATCHDOG_EN
- Defined:
  - An 8+-bit counter runs in HALT_WAIT.
  - If cpu_halted is not seen within HALT_TIMEOUT cycles, drop cpu_halt_req, set sticky halt_timeout, go → IDLE. No copy_start is issued and no frame_done is pulsed.
  - halt_timeout is cleared only by reset.
- Undefined: HALT_WAIT waits indefinitely; halt_timeout is tied 0.

Test Plan:
- Basic frame: cpu_halted=1, pulse frame_start at t0 → copy_start at t0+2, gpu_valid at t0+3..t0+386, frame_done at t0+387, mem_sel=0 at t0+387.
- Indices: during COPY → gpu_word_idx sequence 0..5 repeating; gpu_rect_idx steps 0→63, reaching 63 on the last 6 valid cycles; 384 valid cycles total.
- Slow halt: cpu_halted rises 10 cycles after cpu_halt_req → no copy_start before that; copy_start occurs the cycle after cpu_halted is sampled high.
- Overrun: second frame_start 100 cycles into COPY → overrun=1, frame completes normally, exactly one frame_done; overrun_clr → overrun=0; clr coinciding with a new overrun → overrun stays 1.
- Reset mid-COPY: assert reset at COPY cycle 50 → all outputs 0 asynchronously; after release, a new frame_start gives a full 384-cycle copy.
- Watchdog (COPY_WATCHDOG_EN, HALT_TIMEOUT=20): cpu_halted held 0 → cpu_halt_req drops after 20 cycles, halt_timeout=1, no copy_start; without the macro, cpu_halt_req stays high indefinitely.

Source files
------------

// File: rtl/rect_copy_scheduler.sv
// rtl/rect_copy_scheduler.sv - per-frame scheduler for the rectangle DMA copy into the GPU
//
// On each frame_start this block stalls the CPU and hands the data-memory read
// port to the rect copy DMA. It then issues one copy_start and tracks the
// RECT_COUNT x WORDS_PER_RECT word stream for the GPU. When the last word has
// gone out it hands the port back to the CPU and lets the CPU run again.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset (0 = reset)
//   frame_start   single-cycle pulse at vblank start
//   cpu_halted    CPU is stalled at an instruction boundary
//   overrun_clr   clears the sticky overrun flag
//   cpu_halt_req  request CPU stall
//   copy_start    single-cycle start pulse to the DMA
//   mem_sel       1 = DMA owns the data-mem read port, 0 = CPU owns it
//   gpu_valid     current DMA output word is valid for the GPU
//   gpu_word_idx  word index within a packet, 0..5
//   gpu_rect_idx  rect index, 0..63
//   copy_busy     high in every state except IDLE
//   frame_done    single-cycle pulse when the copy is complete
//   overrun       sticky: frame_start arrived while not IDLE
//   halt_timeout  sticky watchdog flag (tied 0 without COPY_WATCHDOG_EN)
//
// Optional feature macro: COPY_WATCHDOG_EN
//   Bounds HALT_WAIT to HALT_TIMEOUT cycles. On expiry the request is dropped,
//   halt_timeout is set and the frame is abandoned.

module rect_copy_scheduler #(
    parameter int RECT_COUNT     = 64,
    parameter int WORDS_PER_RECT = 6,
    parameter int HALT_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       cpu_halted,
    input  logic       overrun_clr,
    output logic       cpu_halt_req,
    output logic       copy_start,
    output logic       mem_sel,
    output logic       gpu_valid,
    output logic [2:0] gpu_word_idx,
    output logic [5:0] gpu_rect_idx,
    output logic       copy_busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       halt_timeout
);

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_RECT - 1);
    localparam logic [5:0] LAST_RECT = 6'(RECT_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_START,
        S_COPY,
        S_RELEASE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_word;
    logic [5:0] r_rect;
    logic       r_overrun;
    logic       w_last;
    logic       w_wd_expire;

    assign w_last = (r_word == LAST_WORD) && (r_rect == LAST_RECT);

`ifdef COPY_WATCHDOG_EN
    localparam int WD_W = ($clog2(HALT_TIMEOUT + 1) > 8) ? $clog2(HALT_TIMEOUT + 1) : 8;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_halt_timeout;

    // The counter value equals the number of HALT_WAIT cycles already spent,
    // so expiry on value HALT_TIMEOUT-1 keeps the request up for exactly
    // HALT_TIMEOUT cycles. A halt seen on the final cycle still wins.
    assign w_wd_expire = (r_state == S_HALT_WAIT) && !cpu_halted &&
                         (r_wd_cnt == WD_W'(HALT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt       <= '0;
            r_halt_timeout <= 1'b0;
        end else begin
            if (r_state == S_HALT_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_wd_expire) begin
                r_halt_timeout <= 1'b1;
            end
        end
    end

    assign halt_timeout = r_halt_timeout;
`else
    logic [31:0] w_unused_halt_timeout;

    assign w_unused_halt_timeout = HALT_TIMEOUT;
    assign w_wd_expire           = 1'b0;
    assign halt_timeout          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every output is decoded from the state and the counters only, so a
    // reset drops them all at once and no input reaches an output directly.
    always_comb begin
        w_next       = r_state;
        cpu_halt_req = 1'b0;
        copy_start   = 1'b0;
        mem_sel      = 1'b0;
        gpu_valid    = 1'b0;
        gpu_word_idx = 3'd0;
        gpu_rect_idx = 6'd0;
        frame_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_next = S_HALT_WAIT;
                end
            end
            S_HALT_WAIT: begin
                cpu_halt_req = 1'b1;
                if (cpu_halted) begin
                    w_next = S_START;
                end else if (w_wd_expire) begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                cpu_halt_req = 1'b1;
                mem_sel      = 1'b1;
                copy_start   = 1'b1;
                w_next       = S_COPY;
            end
            S_COPY: begin
                cpu_halt_req = 1'b1;
                mem_sel      = 1'b1;
                gpu_valid    = 1'b1;
                gpu_word_idx = r_word;
                gpu_rect_idx = r_rect;
                if (w_last) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                frame_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign copy_busy = (r_state != S_IDLE);

    // Word/rect counters track the DMA word currently on the bus. They are
    // zeroed in START so the first COPY cycle presents word 0 of rect 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= 3'd0;
            r_rect <= 6'd0;
        end else if (r_state == S_START) begin
            r_word <= 3'd0;
            r_rect <= 6'd0;
        end else if (r_state == S_COPY) begin
            if (r_word == LAST_WORD) begin
                r_word <= 3'd0;
                r_rect <= r_rect + 6'd1;
            end else begin
                r_word <= r_word + 3'd1;
            end
        end
    end

    // A frame event that arrives while a frame is in flight is dropped, not
    // queued; the flag records it. Setting takes priority over clearing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (frame_start && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;

endmodule

// File: tb/tb_rect_copy_scheduler.sv
// tb/tb_rect_copy_scheduler.sv - self-checking bench for rect_copy_scheduler
module tb_rect_copy_scheduler;

    localparam int NRECT   = 64;
    localparam int NWORD   = 6;
    localparam int NCOPY   = NRECT * NWORD;
    localparam int WD_TIME = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       cpu_halted;
    logic       overrun_clr;
    logic       cpu_halt_req;
    logic       copy_start;
    logic       mem_sel;
    logic       gpu_valid;
    logic [2:0] gpu_word_idx;
    logic [5:0] gpu_rect_idx;
    logic       copy_busy;
    logic       frame_done;
    logic       overrun;
    logic       halt_timeout;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_cs   = 0;
    int n_fd   = 0;
    int exp_q[$];

    rect_copy_scheduler #(
        .RECT_COUNT    (NRECT),
        .WORDS_PER_RECT(NWORD),
        .HALT_TIMEOUT  (WD_TIME)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .cpu_halted  (cpu_halted),
        .overrun_clr (overrun_clr),
        .cpu_halt_req(cpu_halt_req),
        .copy_start  (copy_start),
        .mem_sel     (mem_sel),
        .gpu_valid   (gpu_valid),
        .gpu_word_idx(gpu_word_idx),
        .gpu_rect_idx(gpu_rect_idx),
        .copy_busy   (copy_busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .halt_timeout(halt_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every valid GPU word must match the next expected
    // {rect, word} pair queued when the frame was launched.
    always @(negedge clk) begin
        if (copy_start) n_cs++;
        if (frame_done) n_fd++;
        if (gpu_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 1, 0);
            end else begin
                chk("sb_idx", int'(gpu_rect_idx) * 8 + int'(gpu_word_idx), exp_q.pop_front());
            end
        end
    end

    task automatic push_frame();
        for (int r = 0; r < NRECT; r++)
            for (int w = 0; w < NWORD; w++)
                exp_q.push_back(r * 8 + w);
    endtask

    // Pulses frame_start for one cycle; returns at the negedge of cycle t0+1.
    task automatic pulse_frame(input bit expect_copy);
        @(negedge clk);
        frame_start = 1'b1;
        if (expect_copy) push_frame();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Called at the negedge of the START cycle. Runs the COPY phase and the
    // RELEASE cycle; kind 1 injects a stray frame_start at COPY cycle inj,
    // kind 2 does the same together with overrun_clr.
    task automatic finish_copy(input int inj, input int kind);
        int nvalid;
        int nmem;
        nvalid = 0;
        nmem   = 0;
        chk("start_copy_start", copy_start, 1);
        chk("start_mem_sel", mem_sel, 1);
        chk("start_gpu_valid", gpu_valid, 0);
        for (int i = 0; i < NCOPY; i++) begin
            @(negedge clk);
            if (gpu_valid) nvalid++;
            if (mem_sel && cpu_halt_req && !copy_start) nmem++;
            if (kind != 0 && i == inj + 1) begin
                frame_start = 1'b0;
                overrun_clr = 1'b0;
                chk("overrun_set", overrun, 1);
            end
            if (kind != 0 && i == inj) begin
                frame_start = 1'b1;
                if (kind == 2) overrun_clr = 1'b1;
            end
        end
        chk("copy_valid_cycles", nvalid, NCOPY);
        chk("copy_owner_cycles", nmem, NCOPY);
        @(negedge clk);
        chk("release_frame_done", frame_done, 1);
        chk("release_mem_sel", mem_sel, 0);
        chk("release_halt_req", cpu_halt_req, 0);
        chk("release_gpu_valid", gpu_valid, 0);
        @(negedge clk);
        chk("idle_busy", copy_busy, 0);
        chk("idle_frame_done", frame_done, 0);
    endtask

    task automatic basic_frame(input int inj, input int kind);
        int cs0;
        int fd0;
        cs0 = n_cs;
        fd0 = n_fd;
        cpu_halted = 1'b1;
        pulse_frame(1'b1);
        chk("hw_halt_req", cpu_halt_req, 1);
        chk("hw_copy_start", copy_start, 0);
        chk("hw_mem_sel", mem_sel, 0);
        chk("hw_busy", copy_busy, 1);
        @(negedge clk);
        finish_copy(inj, kind);
        chk("frame_one_copy_start", n_cs - cs0, 1);
        chk("frame_one_done", n_fd - fd0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int early;
        int reqcnt;
        int fd0;
        int cs0;
        reset       = 1'b0;
        frame_start = 1'b0;
        cpu_halted  = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_halt_req", cpu_halt_req, 0);
        chk("rst_copy_start", copy_start, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_gpu_valid", gpu_valid, 0);
        chk("rst_idx", int'(gpu_rect_idx) * 8 + int'(gpu_word_idx), 0);
        chk("rst_busy", copy_busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_halt_timeout", halt_timeout, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with the CPU already halted.
        basic_frame(0, 0);

        // Slow halt: the CPU acknowledges 10 cycles after the request and
        // then lets go of cpu_halted during COPY, which must be ignored.
        cpu_halted = 1'b0;
        pulse_frame(1'b1);
        early = 0;
        for (int i = 0; i < 10; i++) begin
            if (copy_start || !cpu_halt_req || mem_sel) early++;
            @(negedge clk);
        end
        chk("slow_no_early_start", early, 0);
        cpu_halted = 1'b1;
        @(negedge clk);
        cpu_halted = 1'b0;
        finish_copy(0, 0);

        // Overrun during COPY, then clear, then clear colliding with a set.
        fd0 = n_fd;
        basic_frame(100, 1);
        repeat (5) @(negedge clk);
        chk("overrun_no_second_frame", copy_busy, 0);
        chk("overrun_sticky", overrun, 1);
        chk("overrun_frame_done_once", n_fd - fd0, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);
        basic_frame(30, 2);
        chk("overrun_set_beats_clr", overrun, 1);

        // Reset in the middle of COPY.
        cpu_halted = 1'b1;
        pulse_frame(1'b1);
        @(negedge clk);
        chk("mid_copy_start", copy_start, 1);
        repeat (50) @(negedge clk);
        chk("mid_valid_before_rst", gpu_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", gpu_valid, 0);
        chk("mid_rst_mem_sel", mem_sel, 0);
        chk("mid_rst_halt_req", cpu_halt_req, 0);
        chk("mid_rst_busy", copy_busy, 0);
        chk("mid_rst_idx", int'(gpu_rect_idx) * 8 + int'(gpu_word_idx), 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_remaining", exp_q.size(), NCOPY - 50);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        basic_frame(0, 0);

        // Halt never acknowledged.
        cs0 = n_cs;
        fd0 = n_fd;
        cpu_halted = 1'b0;
`ifdef COPY_WATCHDOG_EN
        pulse_frame(1'b0);
        reqcnt = 0;
        for (int i = 0; i < 200 && cpu_halt_req; i++) begin
            reqcnt++;
            @(negedge clk);
        end
        chk("wd_req_cycles", reqcnt, WD_TIME);
        chk("wd_halt_timeout", halt_timeout, 1);
        chk("wd_busy", copy_busy, 0);
        repeat (5) @(negedge clk);
        chk("wd_no_copy_start", n_cs - cs0, 0);
        chk("wd_no_frame_done", n_fd - fd0, 0);
`else
        pulse_frame(1'b1);
        reqcnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (cpu_halt_req && !copy_start) reqcnt++;
            @(negedge clk);
        end
        chk("nowd_req_held", reqcnt, 300);
        chk("nowd_halt_timeout", halt_timeout, 0);
        chk("nowd_no_copy_start", n_cs - cs0, 0);
        cpu_halted = 1'b1;
        @(negedge clk);
        finish_copy(0, 0);
        chk("nowd_frame_done", n_fd - fd0, 1);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
